// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-sequencer types and default widths
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, VALID, FLUSH} state_t;
  localparam int PC_STEP = 4;
  localparam int DEF_PCLEN = 10;
  localparam int DEF_IWIDTH = 32;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC mux (trap / branch / increment / hold); trap path only with PC_ALIGN_CHECK_EN
module pc_next_sel import cpu_pkg::*; #(
  parameter int PCLEN = DEF_PCLEN,
  parameter logic [PCLEN-1:0] TRAP_PC = PCLEN'(10'h3FC)
) (
  input  logic [PCLEN-1:0] pc,
  input  logic             inc,
  input  logic             branch,
  input  logic [PCLEN-1:0] target,
  output logic [PCLEN-1:0] pc_next,
  output logic             trap
);
`ifdef PC_ALIGN_CHECK_EN
  assign trap = branch & |target[1:0];
`else
  assign trap = 1'b0;
`endif
  always_comb pc_next = trap ? TRAP_PC : branch ? target : inc ? pc + PCLEN'(PC_STEP) : pc;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC owner and imem request sequencer with one-entry instruction slot; optional PC_ALIGN_CHECK_EN
module pc_fetch_ctrl import cpu_pkg::*; #(
  parameter int PCLEN = DEF_PCLEN,
  parameter logic [PCLEN-1:0] RESET_PC = '0,
  parameter int IWIDTH = DEF_IWIDTH,
  parameter logic [PCLEN-1:0] TRAP_PC = PCLEN'(10'h3FC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branchTaken,
  input  logic [PCLEN-1:0]  branchTarget,
  output logic              imemReq,
  output logic [PCLEN-1:0]  imemAddr,
  input  logic              imemAck,
  input  logic [IWIDTH-1:0] imemData,
  output logic [IWIDTH-1:0] instr,
  output logic [PCLEN-1:0]  instrPc,
  output logic              instrValid,
  output logic              misalign
);
  state_t state, state_nx;
  logic [PCLEN-1:0] pc, pc_nx, pend;
  logic inc, trap;
  assign inc = (state == REQ) & imemAck & !branchTaken;
  pc_next_sel #(.PCLEN(PCLEN), .TRAP_PC(TRAP_PC)) u_sel (
    .pc(pc), .inc(inc), .branch(branchTaken), .target(branchTarget),
    .pc_next(pc_nx), .trap(trap)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = REQ;
      REQ:   state_nx = branchTaken ? (imemAck ? REQ : FLUSH) : (imemAck ? VALID : REQ);
      VALID: state_nx = (branchTaken | !stall) ? REQ : VALID;
      FLUSH: state_nx = imemAck ? REQ : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  // FLUSH keeps presenting the pre-branch address until the ack closes it
  always_comb begin
    imemReq = (state == REQ) | (state == FLUSH);
    imemAddr = (state == FLUSH) ? pend : pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      pend <= RESET_PC;
      instr <= '0;
      instrPc <= '0;
      instrValid <= 1'b0;
    end else begin
      pc <= pc_nx;
      if (state != FLUSH) pend <= pc;
      if (inc) begin
        instr <= imemData;
        instrPc <= pc;
      end
      instrValid <= inc | (instrValid & stall & !branchTaken);
    end
  end
`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) misalign <= rst ? 1'b0 : misalign | trap;
`else
  assign misalign = trap;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenarios plus randomized run against a transaction-level fetch model
module tb_pc_fetch_ctrl;
  localparam logic [9:0] TRAP = 10'h3FC;
  logic clk = 0, rst = 1, stall = 0, branchTaken = 0, imemAck = 0;
  logic [9:0] branchTarget = '0, imemAddr, instrPc;
  logic [31:0] imemData = '0, instr;
  logic imemReq, instrValid, misalign;
  int vectors = 0, errors = 0;
  bit m_idle, m_req, m_disc, m_have, m_mis;
  logic [9:0] m_pc, m_addr, m_ipc, tg;
  logic [31:0] m_instr;

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instr(instr), .instrPc(instrPc), .instrValid(instrValid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // fetch modelled as transactions: an open request, a pending discard, and a held instruction
  task automatic model_step();
    if (rst) begin
      m_idle = 1; m_req = 0; m_disc = 0; m_have = 0; m_mis = 0;
      m_pc = '0; m_addr = '0; m_ipc = '0; m_instr = '0;
    end else begin
      tg = branchTarget;
`ifdef PC_ALIGN_CHECK_EN
      if (branchTaken && tg[1:0] != 2'b00) begin tg = TRAP; m_mis = 1; end
`endif
      if (m_idle) begin
        m_idle = 0;
        if (branchTaken) m_pc = tg;
        m_req = 1; m_addr = m_pc; m_disc = 0;
      end else if (m_req) begin
        if (imemAck) begin
          if (m_disc || branchTaken) begin
            if (branchTaken) m_pc = tg;
            m_addr = m_pc; m_disc = 0;
          end else begin
            m_have = 1; m_instr = imemData; m_ipc = m_addr; m_pc = m_addr + 10'd4; m_req = 0;
          end
        end else if (branchTaken) begin
          m_pc = tg; m_disc = 1;
        end
      end else if (m_have && (branchTaken || !stall)) begin
        if (branchTaken) m_pc = tg;
        m_have = 0; m_req = 1; m_addr = m_pc; m_disc = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; branchTaken = 0; imemAck = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    imemAck = 1;
    do_reset();
    vectors++;
    if ({imemReq, instrValid, misalign} !== 3'b000 || instr !== 32'h0 || instrPc !== 10'h0) begin
      errors++;
      $display("FAIL reset got req=%b v=%b mis=%b instr=%h pc=%h want all zero", imemReq, instrValid, misalign, instr, instrPc);
    end
    imemAck = 0;
  endtask

  task automatic test_sequential();
    do_reset();
    imemAck = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      imemData = 32'hA000_0000 + i;
      vectors++;
      if (imemReq !== 1'b1 || imemAddr !== 10'(i * 4)) begin
        errors++; $display("FAIL seq_addr[%0d] got req=%b addr=%h want 1/%h", i, imemReq, imemAddr, 10'(i * 4));
      end
      tick();
      vectors++;
      if (instrValid !== 1'b1 || instrPc !== 10'(i * 4) || instr !== 32'hA000_0000 + i || imemReq !== 1'b0) begin
        errors++; $display("FAIL seq_valid[%0d] got v=%b pc=%h instr=%h req=%b want 1/%h", i, instrValid, instrPc, instr, imemReq, 10'(i * 4));
      end
      tick();
      vectors++;
      if (instrValid !== 1'b0) begin
        errors++; $display("FAIL seq_gap[%0d] got v=%b want 0", i, instrValid);
      end
    end
    imemAck = 0;
  endtask

  task automatic test_wait();
    do_reset();
    imemAck = 0;
    tick();
    imemAck = 1;
    tick();
    imemAck = 0;
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (imemReq !== 1'b1 || imemAddr !== 10'h4 || instrValid !== 1'b0) begin
        errors++; $display("FAIL wait_hold[%0d] got req=%b addr=%h v=%b want 1/004/0", k, imemReq, imemAddr, instrValid);
      end
      imemAck = (k == 3);
      imemData = 32'h0000_5A5A;
      tick();
    end
    imemAck = 0;
    vectors++;
    if (instrValid !== 1'b1 || instrPc !== 10'h4 || instr !== 32'h0000_5A5A) begin
      errors++; $display("FAIL wait_pulse got v=%b pc=%h instr=%h want 1/004/00005a5a", instrValid, instrPc, instr);
    end
    tick();
    vectors++;
    if (instrValid !== 1'b0) begin
      errors++; $display("FAIL wait_single got v=%b want 0", instrValid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    stall = 1;
    imemAck = 1;
    imemData = 32'hDEADBEEF;
    tick();
    tick();
    imemAck = 0;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (instrValid !== 1'b1 || instr !== 32'hDEADBEEF || instrPc !== 10'h0 || imemReq !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b instr=%h pc=%h req=%b want 1/deadbeef/000/0", k, instrValid, instr, instrPc, imemReq);
      end
      tick();
    end
    stall = 0;
    vectors++;
    if (instrValid !== 1'b1 || imemReq !== 1'b0) begin
      errors++; $display("FAIL stall_last got v=%b req=%b want 1/0", instrValid, imemReq);
    end
    tick();
    vectors++;
    if (imemReq !== 1'b1 || imemAddr !== 10'h4 || instrValid !== 1'b0) begin
      errors++; $display("FAIL stall_resume got req=%b addr=%h v=%b want 1/004/0", imemReq, imemAddr, instrValid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    imemAck = 1;
    repeat (5) tick();
    imemAck = 0;
    branchTaken = 1;
    branchTarget = 10'h100;
    tick();
    branchTaken = 0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (imemReq !== 1'b1 || imemAddr !== 10'h8 || instrValid !== 1'b0) begin
        errors++; $display("FAIL flush_hold[%0d] got req=%b addr=%h v=%b want 1/008/0", k, imemReq, imemAddr, instrValid);
      end
      imemAck = (k == 1);
      tick();
    end
    imemAck = 0;
    vectors++;
    if (imemReq !== 1'b1 || imemAddr !== 10'h100 || instrValid !== 1'b0) begin
      errors++; $display("FAIL flush_redirect got req=%b addr=%h v=%b want 1/100/0", imemReq, imemAddr, instrValid);
    end
  endtask

  task automatic test_branch_ack();
    do_reset();
    tick();
    imemAck = 1;
    branchTaken = 1;
    branchTarget = 10'h040;
    tick();
    branchTaken = 0;
    imemAck = 0;
    vectors++;
    if (instrValid !== 1'b0 || imemReq !== 1'b1 || imemAddr !== 10'h040) begin
      errors++; $display("FAIL br_ack got v=%b req=%b addr=%h want 0/1/040", instrValid, imemReq, imemAddr);
    end
    imemAck = 1;
    tick();
    imemAck = 0;
    vectors++;
    if (instrValid !== 1'b1 || instrPc !== 10'h040) begin
      errors++; $display("FAIL br_ack_fetch got v=%b pc=%h want 1/040", instrValid, instrPc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    imemAck = 1;
    branchTaken = 1;
    branchTarget = 10'h3FC;
    tick();
    branchTaken = 0;
    vectors++;
    if (imemReq !== 1'b1 || imemAddr !== 10'h3FC) begin
      errors++; $display("FAIL wrap_req got req=%b addr=%h want 1/3fc", imemReq, imemAddr);
    end
    tick();
    vectors++;
    if (instrValid !== 1'b1 || instrPc !== 10'h3FC) begin
      errors++; $display("FAIL wrap_instr got v=%b pc=%h want 1/3fc", instrValid, instrPc);
    end
    tick();
    imemAck = 0;
    vectors++;
    if (imemReq !== 1'b1 || imemAddr !== 10'h000) begin
      errors++; $display("FAIL wrap_next got req=%b addr=%h want 1/000", imemReq, imemAddr);
    end
  endtask

  task automatic test_align();
    do_reset();
    tick();
    imemAck = 1;
    branchTaken = 1;
    branchTarget = 10'h102;
    tick();
    branchTaken = 0;
    imemAck = 0;
`ifdef PC_ALIGN_CHECK_EN
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (misalign !== 1'b1 || (k == 0 && imemAddr !== TRAP)) begin
        errors++; $display("FAIL align_trap[%0d] got mis=%b addr=%h want 1/%h", k, misalign, imemAddr, TRAP);
      end
      tick();
    end
`else
    vectors++;
    if (misalign !== 1'b0 || imemAddr !== 10'h102) begin
      errors++; $display("FAIL align_off got mis=%b addr=%h want 0/102", misalign, imemAddr);
    end
`endif
    do_reset();
    vectors++;
    if (misalign !== 1'b0) begin
      errors++; $display("FAIL align_clear got mis=%b want 0", misalign);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      vectors++;
      if (imemReq !== m_req || (m_req && imemAddr !== m_addr) || instrValid !== m_have ||
          instr !== m_instr || instrPc !== m_ipc || misalign !== m_mis) begin
        errors++;
        $display("FAIL random[%0d] got req=%b addr=%h v=%b instr=%h pc=%h mis=%b want %b/%h/%b/%h/%h/%b",
                 n, imemReq, imemAddr, instrValid, instr, instrPc, misalign, m_req, m_addr, m_have, m_instr, m_ipc, m_mis);
      end
      rst = ($urandom_range(99) == 0);
      stall = $urandom_range(1);
      branchTaken = ($urandom_range(7) == 0);
      branchTarget = 10'($urandom);
      if ($urandom_range(3) != 0) branchTarget[1:0] = 2'b00;
      imemAck = $urandom_range(1);
      imemData = $urandom;
      tick();
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_flush();
    test_branch_ack();
    test_wrap();
    test_align();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
